// File: rtl/mem_wb_drain.sv
// Write-buffer drain: pops one line from the write-buffer FIFO and writes it to memory as BEATS req/ack beats.
// Optional macro WB_TIMEOUT_EN adds a per-beat ack timeout that abandons the line and pulses err.
module mem_wb_drain #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 128,
    parameter int BEAT_WIDTH    = 32
`ifdef WB_TIMEOUT_EN
    ,
    parameter int TIMEOUT       = 255
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic [ADDRESS_WIDTH-1:0] fifo_address,
    input  logic [DATA_WIDTH-1:0]    fifo_data,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [BEAT_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    output logic                     busy,
    output logic [15:0]              lines_written,
    output logic                     err
);

    // DATA_WIDTH is assumed to be an integer multiple of BEAT_WIDTH.
    localparam int BEATS      = DATA_WIDTH / BEAT_WIDTH;
    localparam int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_BYTES = BEAT_WIDTH / 8;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_POP     = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_REQ     = 2'd3;

    logic [1:0]               state_q,     state_d;
    logic [IDX_W-1:0]         beat_idx_q,  beat_idx_d;
    logic [ADDRESS_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [DATA_WIDTH-1:0]    line_data_q, line_data_d;
    logic [15:0]              lines_q,     lines_d;

    logic                     in_req;
    logic                     last_beat;
    logic [ADDRESS_WIDTH-1:0] beat_offset;
    logic [BEAT_WIDTH-1:0]    beat_word [BEATS];

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            assign beat_word[gi] = line_data_q[gi*BEAT_WIDTH +: BEAT_WIDTH];
        end
    endgenerate

    assign in_req      = (state_q == S_REQ);
    assign last_beat   = (beat_idx_q == IDX_W'(BEATS - 1));
    assign beat_offset = ADDRESS_WIDTH'(beat_idx_q) * ADDRESS_WIDTH'(BEAT_BYTES);

    // Beat address/data are forced to zero outside REQ so idle outputs stay quiet.
    assign fifo_rd_en    = (state_q == S_POP);
    assign busy          = (state_q != S_IDLE);
    assign mem_req       = in_req;
    assign mem_we        = in_req;
    assign mem_addr      = in_req ? (line_addr_q + beat_offset) : '0;
    assign mem_wdata     = in_req ? beat_word[beat_idx_q] : '0;
    assign lines_written = lines_q;

`ifdef WB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q,  err_d;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        beat_idx_d  = beat_idx_q;
        line_addr_d = line_addr_q;
        line_data_d = line_data_q;
        lines_d     = lines_q;
`ifdef WB_TIMEOUT_EN
        wait_d      = wait_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                line_addr_d = fifo_address;
                line_data_d = fifo_data;
                beat_idx_d  = '0;
                state_d     = S_REQ;
`ifdef WB_TIMEOUT_EN
                wait_d      = '0;
`endif
            end
            S_REQ: begin
                if (mem_ack) begin
`ifdef WB_TIMEOUT_EN
                    wait_d = '0;
`endif
                    if (last_beat) begin
                        lines_d    = lines_q + 16'd1;
                        beat_idx_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end
                end
`ifdef WB_TIMEOUT_EN
                // TIMEOUT unacknowledged REQ cycles abandon the line without counting it.
                else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    beat_idx_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            beat_idx_q  <= '0;
            line_addr_q <= '0;
            line_data_q <= '0;
            lines_q     <= '0;
`ifdef WB_TIMEOUT_EN
            wait_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            line_addr_q <= line_addr_d;
            line_data_q <= line_data_d;
            lines_q     <= lines_d;
`ifdef WB_TIMEOUT_EN
            wait_q      <= wait_d;
            err_q       <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_wb_drain.sv
// Self-checking bench for mem_wb_drain: FIFO model, beat scoreboard, vector table and corner-case sequences.
module tb_mem_wb_drain;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fifo_empty = 1'b1;
    logic         fifo_rd_en;
    logic [31:0]  fifo_address = '0;
    logic [127:0] fifo_data = '0;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack = 1'b0;
    logic         busy;
    logic [15:0]  lines_written;
    logic         err;

    always #5 clk = ~clk;

    mem_wb_drain #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(128),
        .BEAT_WIDTH(32)
`ifdef WB_TIMEOUT_EN
        ,
        .TIMEOUT(8)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_address(fifo_address),
        .fifo_data(fifo_data),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .busy(busy),
        .lines_written(lines_written),
        .err(err)
    );

    typedef struct packed {
        logic [31:0]  a;
        logic [127:0] d;
    } ent_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } beat_t;

    typedef struct {
        logic [31:0]      addr;
        logic [127:0]     data;
        int               stall_beat;
        int               stall_len;
        logic             noise;
        logic [3:0][31:0] ea;
        logic [3:0][31:0] ed;
        int               el;
    } vec_t;

    ent_t  fifo_q[$];
    beat_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor / ack-driver state
    int   cyc = 0, beat_no = 0, stall_beat = -1, stall_len = 0, stall_done = 0;
    int   low_run = 0, last_gap = 0, rd_cyc = 0, fin_cyc = 0, fin_prev = 0;
    logic noise = 1'b0;
    int   tcyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    // FIFO read side: outputs valid the cycle after the pop, empty flag lags the count.
    always @(posedge clk) begin
        fifo_empty <= (fifo_q.size() == 0);
        if (fifo_rd_en && fifo_q.size() != 0) begin
            fifo_address <= fifo_q[0].a;
            fifo_data    <= fifo_q[0].d;
            fifo_q.delete(0);
        end else begin
            fifo_address <= '0;
            fifo_data    <= '0;
        end
    end

    // Beat scoreboard and ack driver; the ack chosen here is sampled at the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mem_ack    = 1'b0;
            beat_no    = 0;
            stall_done = 0;
            low_run    = 0;
        end else begin
            if (fifo_rd_en) begin
                check("rd_en_while_req", mem_req, 0);
                rd_cyc = cyc;
            end
            if (mem_req) begin
                if (low_run > 0) last_gap = low_run;
                low_run = 0;
            end else begin
                low_run++;
            end
            if (beat_no != 0) check("req_held_mid_line", mem_req, 1);
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got addr 0x%0h, required no beat", mem_addr);
                    mem_ack = 1'b1;
                end else begin
                    check("beat_addr", mem_addr, exp_q[0].a);
                    check("beat_data", mem_wdata, exp_q[0].d);
                    check("mem_we", mem_we, 1);
                    if (beat_no == stall_beat && stall_done < stall_len) begin
                        mem_ack = 1'b0;
                        stall_done++;
                    end else begin
                        mem_ack = 1'b1;
                        exp_q.delete(0);
                        beat_no = (beat_no + 1) % 4;
                        if (beat_no == 0) begin
                            fin_prev   = fin_cyc;
                            fin_cyc    = cyc;
                            stall_done = 0;
                        end
                    end
                end
            end else begin
                mem_ack = noise;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        tcyc++;
    endtask

    task automatic push_line(input logic [31:0] addr, input logic [127:0] data,
                             input logic [3:0][31:0] ea, input logic [3:0][31:0] ed);
        fifo_q.push_back('{a: addr, d: data});
        for (int i = 0; i < 4; i++) exp_q.push_back('{a: ea[i], d: ed[i]});
    endtask

    task automatic wait_lines(input int target, input string name);
        int k = 0;
        while (lines_written != 16'(target) && k < 400) begin
            tick();
            k++;
        end
        check(name, lines_written, target);
    endtask

    vec_t vecs[3];

    initial begin
        int k, t0, te, errs, prev;

        vecs[0] = '{32'h0000_1000, 128'h44444444_33333333_22222222_11111111, 1, 3, 1'b0,
                    {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1000},
                    {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 2};
        vecs[1] = '{32'hFFFF_FFF8, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 3, 1, 1'b1,
                    {32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8},
                    {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, 3};
        vecs[2] = '{32'h0000_0100, 128'h0F0E0D0C_0B0A0908_07060504_03020100, -1, 0, 1'b1,
                    {32'h0000_010C, 32'h0000_0108, 32'h0000_0104, 32'h0000_0100},
                    {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100}, 4};

        // Reset held with a non-empty FIFO
        push_line(32'h1000, 128'h44444444_33333333_22222222_11111111,
                  {32'h100C, 32'h1008, 32'h1004, 32'h1000},
                  {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rd_en", fifo_rd_en, 0);
            check("rst_mem_req", mem_req, 0);
            check("rst_busy", busy, 0);
            check("rst_err", err, 0);
            check("rst_lines", lines_written, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
        end
        rst_n = 1'b1;
        check("rd_en_cycle1", fifo_rd_en, 0);
        tick();
        check("rd_en_cycle2", fifo_rd_en, 1);
        tick();
        check("rd_en_one_pulse", fifo_rd_en, 0);
        wait_lines(1, "lines_single");

        // Vector table: stalls, address wrap, ack noise while idle
        for (int i = 0; i < 3; i++) begin
            stall_beat = vecs[i].stall_beat;
            stall_len  = vecs[i].stall_len;
            noise      = vecs[i].noise;
            push_line(vecs[i].addr, vecs[i].data, vecs[i].ea, vecs[i].ed);
            wait_lines(vecs[i].el, "lines_vec");
            check("idle_after_line", busy, 0);
            for (int j = 0; j < 3; j++) begin
                tick();
                check("idle_no_req", mem_req, 0);
            end
        end
        stall_beat = -1;
        stall_len  = 0;
        noise      = 1'b0;

        // Back-to-back lines
        push_line(32'h2000, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0,
                  {32'h200C, 32'h2008, 32'h2004, 32'h2000},
                  {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0});
        push_line(32'h3000, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0,
                  {32'h300C, 32'h3008, 32'h3004, 32'h3000},
                  {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0});
        wait_lines(6, "lines_b2b");
        check("b2b_pop_after_final_ack", rd_cyc - fin_prev, 2);
        check("b2b_req_low_gap", last_gap, 3);

        // Reset while beat 2 is pending
        stall_beat = 2;
        stall_len  = 1000;
        push_line(32'h1000, 128'h44444444_33333333_22222222_11111111,
                  {32'h100C, 32'h1008, 32'h1004, 32'h1000},
                  {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        k = 0;
        while (!(mem_req && mem_addr == 32'h1008) && k < 100) begin
            tick();
            k++;
        end
        check("midline_beat2_pending", mem_addr, 32'h1008);
        rst_n = 1'b0;
        tick();
        check("midrst_mem_req", mem_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_lines", lines_written, 0);
        exp_q.delete();
        stall_beat = -1;
        stall_len  = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_no_beat3", mem_req, 0);
        end
        check("midrst_lines_after", lines_written, 0);

`ifdef WB_TIMEOUT_EN
        // Ack withheld: line abandoned after TIMEOUT cycles, next entry still drained
        prev       = int'(lines_written);
        stall_beat = 0;
        stall_len  = 1000;
        push_line(32'h5000, 128'h53535353_52525252_51515151_50505050,
                  {32'h500C, 32'h5008, 32'h5004, 32'h5000},
                  {32'h53535353, 32'h52525252, 32'h51515151, 32'h50505050});
        push_line(32'h6000, 128'h63636363_62626262_61616161_60606060,
                  {32'h600C, 32'h6008, 32'h6004, 32'h6000},
                  {32'h63636363, 32'h62626262, 32'h61616161, 32'h60606060});
        k = 0;
        while (!mem_req && k < 50) begin
            tick();
            k++;
        end
        check("to_req_seen", mem_req, 1);
        t0   = tcyc;
        te   = -1;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (err) begin
                errs++;
                if (errs == 1) begin
                    te = tcyc;
                    check("to_lines_unchanged", lines_written, prev);
                    check("to_idle_on_err", busy, 0);
                    for (int j = 0; j < 4; j++) exp_q.delete(0);
                    stall_beat = -1;
                    stall_len  = 0;
                    stall_done = 0;
                end
            end
        end
        check("to_err_latency", te - t0, 8);
        check("to_err_pulses", errs, 1);
        wait_lines(prev + 1, "to_next_line");
`else
        t0 = 0; te = 0; errs = 0; prev = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
